// File: rtl/stream_teacher_aligner.sv
// stream_teacher_aligner
// First-word-fall-through FIFO between an upstream and a downstream teacher stream.
// Each lane is widened from WF to WF+EXT bits on the way out.
// The block also counts samples per epoch.
// In TEST mode every upstream word is accepted and dropped.
// Leaving TRAIN flushes whatever is still buffered.
// Build option: define TEACHER_SIGN_EXT_EN to sign-extend the lanes instead of zero-extending them.
module stream_teacher_aligner #(
  parameter int NO    = 2,
  parameter int WF    = 8,
  parameter int EXT   = 2,
  parameter int DEPTH = 4,
  parameter int SIZE  = 1,
  localparam int WO   = WF + EXT,
  localparam int LW   = $clog2(DEPTH) + 1,
  localparam int CW   = $clog2(SIZE) + 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iMode,
  input  logic             iValid_AM_Teacher,
  output logic             oReady_AM_Teacher,
  input  logic [NO*WF-1:0] iData_AM_Teacher,
  output logic             oValid_BM_Teacher,
  input  logic             iReady_BM_Teacher,
  output logic [NO*WO-1:0] oData_BM_Teacher,
  output logic [LW-1:0]    oLevel,
  output logic [CW-1:0]    oCount,
  output logic             oEpochDone
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(SIZE - 1);

  logic [NO*WF-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_mode_prev;
  logic             r_rdy_en;
  logic [CW-1:0]    r_count;
  logic             r_epoch_done;

  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_mode_chg;
  logic             w_event;
  logic [NO*WF-1:0] w_head;

  // Ready depends only on local state and mode, never on the downstream ready.
  // It is held low until the first clock edge after reset.
  assign w_full     = (r_level == FULL_LEVEL);
  assign w_empty    = (r_level == '0);
  assign w_ready    = r_rdy_en & (iMode ? ~w_full : 1'b1);
  assign w_valid    = iMode & ~w_empty;
  assign w_push     = iValid_AM_Teacher & w_ready & iMode;
  assign w_pop      = w_valid & iReady_BM_Teacher;
  assign w_flush    = r_mode_prev & ~iMode;
  assign w_mode_chg = (iMode != r_mode_prev);
  assign w_event    = iMode ? w_pop : (iValid_AM_Teacher & w_ready);
  assign w_head     = r_mem[r_rd_ptr];

  assign oReady_AM_Teacher = w_ready;
  assign oValid_BM_Teacher = w_valid;
  assign oLevel            = r_level;
  assign oCount            = r_count;
  assign oEpochDone        = r_epoch_done;

  // Widen each lane of the head word. The head word is read combinationally
  // so that a word pushed into an empty FIFO shows up one cycle later.
  for (genvar gi = 0; gi < NO; gi++) begin : g_lane
`ifdef TEACHER_SIGN_EXT_EN
    assign oData_BM_Teacher[gi*WO +: WO] = {{EXT{w_head[gi*WF + WF - 1]}}, w_head[gi*WF +: WF]};
`else
    assign oData_BM_Teacher[gi*WO +: WO] = {{EXT{1'b0}}, w_head[gi*WF +: WF]};
`endif
  end

  // Storage write. There is no reset because occupancy alone defines which entries are valid.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= iData_AM_Teacher;
    end
  end

  // FIFO pointers and occupancy. A TRAIN-to-TEST transition empties the buffer.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Previous mode used for edge detection, plus the post-reset ready enable.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_mode_prev <= 1'b1;
      r_rdy_en    <= 1'b0;
    end else begin
      r_mode_prev <= iMode;
      r_rdy_en    <= 1'b1;
    end
  end

  // Epoch counter. Each counted transfer advances it, and the SIZE-th one wraps
  // the counter and raises a one-cycle pulse. A mode change cleanly restarts the epoch.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_count      <= '0;
      r_epoch_done <= 1'b0;
    end else if (w_mode_chg) begin
      r_count      <= '0;
      r_epoch_done <= 1'b0;
    end else if (w_event) begin
      if (r_count == LAST_COUNT) begin
        r_count      <= '0;
        r_epoch_done <= 1'b1;
      end else begin
        r_count      <= r_count + CW'(1);
        r_epoch_done <= 1'b0;
      end
    end else begin
      r_epoch_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_teacher_aligner.sv
// Randomised and directed bench for stream_teacher_aligner.
// The expected stream is kept as a queue of widened words, and the epoch is tracked as a plain sample counter.
module tb_stream_teacher_aligner;
  localparam int NO = 2, WF = 8, EXT = 2, WO = WF + EXT, DEPTH = 4, SIZE = 3;
  localparam int LW = $clog2(DEPTH) + 1, CW = $clog2(SIZE) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             mode = 1'b1;
  logic             ivalid = 1'b0;
  logic             iready = 1'b0;
  logic [NO*WF-1:0] idata = '0;
  logic             oready;
  logic             ovalid;
  logic [NO*WO-1:0] odata;
  logic [LW-1:0]    olevel;
  logic [CW-1:0]    ocount;
  logic             oepoch;

  stream_teacher_aligner #(.NO(NO), .WF(WF), .EXT(EXT), .DEPTH(DEPTH), .SIZE(SIZE)) dut (
    .iCLK(clk), .iRST(rst_n), .iMode(mode),
    .iValid_AM_Teacher(ivalid), .oReady_AM_Teacher(oready), .iData_AM_Teacher(idata),
    .oValid_BM_Teacher(ovalid), .iReady_BM_Teacher(iready), .oData_BM_Teacher(odata),
    .oLevel(olevel), .oCount(ocount), .oEpochDone(oepoch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected output word, computed lane by lane with integer arithmetic.
  function automatic logic [NO*WO-1:0] widen(input logic [NO*WF-1:0] d);
    logic [NO*WO-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NO; i++) begin
      v = int'(d[i*WF +: WF]);
`ifdef TEACHER_SIGN_EXT_EN
      if (v >= (1 << (WF - 1))) v = v + (((1 << EXT) - 1) << WF);
`endif
      r[i*WO +: WO] = WO'(v);
    end
    return r;
  endfunction

  // Scoreboard and monitor. Outputs are checked at the falling edge.
  // The model is then advanced to the state that the next rising edge will produce.
  logic [NO*WO-1:0] exp_q[$];
  int  exp_cnt = 0;
  bit  exp_done = 1'b0;
  bit  prev_mode = 1'b1;
  bit  rdy_en = 1'b0;

  initial begin
    bit e_ready, e_valid, push, pop;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt = 0; exp_done = 1'b0; prev_mode = 1'b1; rdy_en = 1'b0;
        check("rst_level", 64'(olevel), 64'd0);
        check("rst_valid", 64'(ovalid), 64'd0);
        check("rst_ready", 64'(oready), 64'd0);
        check("rst_count", 64'(ocount), 64'd0);
        check("rst_epoch", 64'(oepoch), 64'd0);
      end else begin
        e_ready = rdy_en && (mode ? (exp_q.size() != DEPTH) : 1'b1);
        e_valid = mode && (exp_q.size() != 0);
        check("ready", 64'(oready), 64'(e_ready));
        check("valid", 64'(ovalid), 64'(e_valid));
        check("level", 64'(olevel), 64'(exp_q.size()));
        check("count", 64'(ocount), 64'(exp_cnt));
        check("epoch", 64'(oepoch), 64'(exp_done));
        if (e_valid) check("data", 64'(odata), 64'(exp_q[0]));
        push = ivalid && e_ready;
        pop  = e_valid && iready;
        if (pop) void'(exp_q.pop_front());
        if (prev_mode && !mode) exp_q.delete();
        else if (push && mode) exp_q.push_back(widen(idata));
        if (mode != prev_mode) begin
          exp_cnt = 0; exp_done = 1'b0;
        end else if (mode ? pop : push) begin
          exp_cnt++;
          exp_done = 1'b0;
          if (exp_cnt == SIZE) begin exp_cnt = 0; exp_done = 1'b1; end
        end else begin
          exp_done = 1'b0;
        end
        prev_mode = mode;
        rdy_en = 1'b1;
      end
    end
  end

  task automatic step(input bit m, input bit v, input logic [NO*WF-1:0] d, input bit r);
    @(posedge clk);
    #1;
    mode = m; ivalid = v; idata = d; iready = r;
  endtask

  initial begin
    bit rm;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, '0, 0);
    // Single push into the empty FIFO, then hold the word and drain it.
    step(1, 1, 16'h7F81, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    step(1, 0, '0, 0);
    // Overfill with the sink stalled, then drain in order.
    for (int i = 0; i < 5; i++) step(1, 1, 16'(16'h1234 + i * 16'h1111), 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, '0, 1);
    // Reach level 2, then push and pop together long enough to wrap the pointers.
    step(1, 1, 16'hA0B0, 0);
    step(1, 1, 16'hC0D0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 16'($urandom), 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
    // Continuous flow to exercise the epoch pulses.
    for (int i = 0; i < 8; i++) step(1, 1, 16'($urandom), 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
    // Reach level 3, then switch to TEST. This flushes the FIFO, and later TEST pushes are counted.
    for (int i = 0; i < 3; i++) step(1, 1, 16'($urandom), 0);
    step(0, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom), 16'($urandom), 1'($urandom));
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    // Reset mid-stream at level 2, then check that the first push has latency 1.
    step(1, 1, 16'h1122, 0);
    step(1, 1, 16'h3344, 0);
    @(posedge clk);
    #1 rst_n = 1'b0; ivalid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, '0, 0);
    step(1, 1, 16'h8001, 0);
    step(1, 0, '0, 1);
    step(1, 0, '0, 0);
    // Random traffic with occasional mode flips and resets.
    rm = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      if ($urandom_range(0, 149) == 0) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step(rm, 1'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1, 0, '0, 1);
    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
